// File: rtl/eth_packet_tx.sv
// eth_packet_tx - transmit framer for the Ethernet packet path.
//
// Emits a 14-byte header (dest MAC, src MAC, type/length, MSB byte first)
// with control high, streams payload from a valid/ready source, zero-pads
// short payloads to MIN_PAYLOAD, then holds control low / data 0x00 for
// IFG_CYCLES cycles. The first gap cycle is the packet terminator.
//
// Optional feature macro: ETH_TX_FCS_EN
//   When defined, a 4-byte CRC-32 (reflected 0x04C11DB7, init all-ones,
//   final complement) over header+payload+pad is appended, LSB first.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   start         packet request, sampled only in IDLE
//   dest_mac      destination MAC, captured on start
//   src_mac       source MAC, captured on start
//   type_length   type/length field, captured on start
//   pl_data       payload byte
//   pl_valid      pl_data valid
//   pl_last       marks final payload byte
//   pl_ready      payload accepted this cycle (combinational)
//   control       high while header/payload/pad/FCS bytes are on data
//   data          output byte
//   busy          high in every state except IDLE
//   done          pulse on the terminator of a normally completed packet
//   underrun_err  pulse on the terminator of an underrun-aborted packet
//   too_long_err  pulse with the byte that reaches MAX_PAYLOAD without pl_last
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | line idle; also the final gap cycle before the next packet
// S_HEADER  | header byte hdr_cnt on data
// S_PAYLOAD | payload byte on data; accepting until pl_end is set
// S_PAD     | zero pad byte on data
// S_FCS     | FCS byte fcs_cnt on data (ETH_TX_FCS_EN only)
// S_IFG     | inter-frame gap, terminator is the first cycle

module eth_packet_tx #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_CYCLES  = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] type_length,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic        control,
  output logic [7:0]  data,
  output logic        busy,
  output logic        done,
  output logic        underrun_err,
  output logic        too_long_err
);

  localparam int CNT_MAX = (MAX_PAYLOAD > MIN_PAYLOAD) ? MAX_PAYLOAD : MIN_PAYLOAD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IFG_W   = $clog2(IFG_CYCLES + 1);

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PAYLOAD);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
  localparam logic [IFG_W-1:0] IFG_ONE  = IFG_W'(1);
  localparam logic [3:0]       HDR_LAST = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PAD,
    S_IFG
`ifdef ETH_TX_FCS_EN
    , S_FCS
`endif
  } state_t;

  state_t             state, state_n, gap_st;
  logic [111:0]       hdr_in;
  logic [111:0]       hdr_sr;
  logic [3:0]         hdr_cnt;
  logic [CNT_W-1:0]   pl_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               pl_end;
  logic [IFG_W-1:0]   ifg_cnt;

  logic hdr_tail, accept, underrun, reach_max, tail, need_pad;
  logic ctl_n, done_n, und_n, tl_n;
  logic [7:0] dat_n;

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] fcs_val;
  logic [1:0]  fcs_cnt;
  logic [7:0]  fcs_sel;
  logic        fcs_phase;
  logic        cov_n;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs_val = ~crc;

  // Byte to show on the next cycle while already inside FCS.
  always_comb begin
    case (fcs_cnt)
      2'd0:    fcs_sel = fcs_val[15:8];
      2'd1:    fcs_sel = fcs_val[23:16];
      default: fcs_sel = fcs_val[31:24];
    endcase
  end
`endif

  assign hdr_in    = {dest_mac, src_mac, type_length};
  assign hdr_tail  = (state == S_HEADER) && (hdr_cnt == HDR_LAST);
  assign pl_ready  = hdr_tail || ((state == S_PAYLOAD) && !pl_end);
  assign accept    = pl_ready && pl_valid;
  assign underrun  = pl_ready && !pl_valid;
  assign cnt_next  = hdr_tail ? ONE_C : (pl_cnt + ONE_C);
  assign reach_max = (cnt_next == MAX_C);
  // Payload finished (last byte already on data) or padding in progress.
  assign tail      = ((state == S_PAYLOAD) && pl_end) || (state == S_PAD);
  assign need_pad  = (pl_cnt < MIN_C);
  assign busy      = (state != S_IDLE);

  // The IDLE cycle itself counts as the last gap cycle, so a held start
  // yields exactly IFG_CYCLES low-control cycles between packets.
  always_comb begin
    if (IFG_CYCLES > 1) gap_st = S_IFG;
    else                gap_st = S_IDLE;
  end

  // State register, datapath and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      control      <= 1'b0;
      data         <= 8'h00;
      done         <= 1'b0;
      underrun_err <= 1'b0;
      too_long_err <= 1'b0;
      hdr_sr       <= '0;
      hdr_cnt      <= '0;
      pl_cnt       <= '0;
      pl_end       <= 1'b0;
      ifg_cnt      <= '0;
`ifdef ETH_TX_FCS_EN
      crc          <= '0;
      fcs_cnt      <= '0;
`endif
    end else begin
      state        <= state_n;
      control      <= ctl_n;
      data         <= dat_n;
      done         <= done_n;
      underrun_err <= und_n;
      too_long_err <= tl_n;

      if ((state == S_IDLE) && start) begin
        hdr_sr  <= {hdr_in[103:0], 8'h00};
        hdr_cnt <= 4'd0;
        pl_cnt  <= '0;
        pl_end  <= 1'b0;
      end else if ((state == S_HEADER) && !hdr_tail) begin
        hdr_sr  <= {hdr_sr[103:0], 8'h00};
        hdr_cnt <= hdr_cnt + 4'd1;
      end

      if (accept) begin
        pl_cnt <= cnt_next;
        pl_end <= pl_last | reach_max;
      end else if (tail && need_pad) begin
        pl_cnt <= pl_cnt + ONE_C;
      end

      if ((state_n == S_IFG) && (state != S_IFG)) ifg_cnt <= IFG_ONE;
      else if (state == S_IFG)                     ifg_cnt <= ifg_cnt + IFG_ONE;

`ifdef ETH_TX_FCS_EN
      if (cov_n) crc <= crc32_byte((state == S_IDLE) ? 32'hFFFFFFFF : crc, dat_n);
      if (tail && !need_pad)   fcs_cnt <= 2'd0;
      else if (state == S_FCS) fcs_cnt <= fcs_cnt + 2'd1;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    if (accept) begin
      state_n = S_PAYLOAD;
    end else if (underrun) begin
      state_n = gap_st;
    end else begin
      case (state)
        S_IDLE:   if (start) state_n = S_HEADER;
        S_PAYLOAD,
        S_PAD: begin
          if (tail) begin
            if (need_pad) state_n = S_PAD;
`ifdef ETH_TX_FCS_EN
            else          state_n = S_FCS;
`else
            else          state_n = gap_st;
`endif
          end
        end
`ifdef ETH_TX_FCS_EN
        S_FCS:    if (fcs_cnt == 2'd3) state_n = gap_st;
`endif
        S_IFG:    if (ifg_cnt == IFG_LAST) state_n = S_IDLE;
        default:  state_n = state;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    ctl_n  = 1'b0;
    dat_n  = 8'h00;
    done_n = 1'b0;
    und_n  = 1'b0;
    tl_n   = 1'b0;
    if (accept) begin
      ctl_n = 1'b1;
      dat_n = pl_data;
      tl_n  = reach_max & ~pl_last;
    end else if (underrun) begin
      und_n = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ctl_n = 1'b1;
            dat_n = hdr_in[111:104];
          end
        end
        S_HEADER: begin
          ctl_n = 1'b1;
          dat_n = hdr_sr[111:104];
        end
        S_PAYLOAD,
        S_PAD: begin
          if (tail) begin
            if (need_pad) begin
              ctl_n = 1'b1;
            end else begin
`ifdef ETH_TX_FCS_EN
              ctl_n = 1'b1;
              dat_n = fcs_val[7:0];
`else
              done_n = 1'b1;
`endif
            end
          end
        end
`ifdef ETH_TX_FCS_EN
        S_FCS: begin
          if (fcs_cnt != 2'd3) begin
            ctl_n = 1'b1;
            dat_n = fcs_sel;
          end else begin
            done_n = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef ETH_TX_FCS_EN
  // FCS bytes themselves are not folded into the CRC.
  assign fcs_phase = (state == S_FCS) || (tail && !need_pad);
  assign cov_n     = ctl_n && !fcs_phase;
`endif

endmodule

// File: tb/tb_eth_packet_tx.sv
module tb_eth_packet_tx;

  localparam int MIN_P = 46;
  localparam int MAX_P = 64;
  localparam int IFG   = 12;
`ifdef ETH_TX_FCS_EN
  localparam bit FCS = 1'b1;
`else
  localparam bit FCS = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic        clock, reset, start;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] type_length;
  logic [7:0]  pl_data;
  logic        pl_valid, pl_last, pl_ready;
  logic        control, busy, done, underrun_err, too_long_err;
  logic [7:0]  data;

  int checks = 0;
  int errors = 0;

  eth_packet_tx #(
    .MIN_PAYLOAD(MIN_P),
    .MAX_PAYLOAD(MAX_P),
    .IFG_CYCLES (IFG)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dest_mac    (dest_mac),
    .src_mac     (src_mac),
    .type_length (type_length),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_last     (pl_last),
    .pl_ready    (pl_ready),
    .control     (control),
    .data        (data),
    .busy        (busy),
    .done        (done),
    .underrun_err(underrun_err),
    .too_long_err(too_long_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-32 (IEEE 802.3, reflected), complemented.
  function automatic logic [31:0] crc_ref(input byte_q_t q);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  // Expected per-cycle word: {busy, too_long, underrun, done, control, data}
  function automatic logic [12:0] mk(input bit b, input bit tl, input bit un,
                                     input bit dn, input bit c, input logic [7:0] d);
    return {b, tl, un, dn, c, d};
  endfunction

  // Called at a falling edge while the DUT is idle; returns at the falling
  // edge of the last gap cycle, with start still high for chaining.
  task automatic run_packet(input logic [47:0] dm, input logic [47:0] sm, input logic [15:0] tl,
                            input byte_q_t pay, input bit has_last, input int u, input int id);
    int          n, sent, k;
    bit          tl_hit;
    logic [111:0] hdr;
    logic [7:0]  b;
    logic [31:0] c;
    byte_q_t     cov;
    logic [12:0] exp[$];

    n   = pay.size();
    hdr = {dm, sm, tl};
    if (u >= 0)                      sent = u;
    else if (has_last && n <= MAX_P) sent = n;
    else                             sent = MAX_P;
    tl_hit = (u < 0) && !(has_last && n <= MAX_P);

    for (int i = 0; i < 14; i++) begin
      b = hdr[111 - 8*i -: 8];
      cov.push_back(b);
      exp.push_back(mk(1, 0, 0, 0, 1, b));
    end
    for (int i = 0; i < sent; i++) begin
      cov.push_back(pay[i]);
      exp.push_back(mk(1, tl_hit && (i == sent - 1), 0, 0, 1, pay[i]));
    end
    if (u < 0) begin
      for (int i = sent; i < MIN_P; i++) begin
        cov.push_back(8'h00);
        exp.push_back(mk(1, 0, 0, 0, 1, 8'h00));
      end
      if (FCS) begin
        c = crc_ref(cov);
        for (int i = 0; i < 4; i++) exp.push_back(mk(1, 0, 0, 0, 1, c[8*i +: 8]));
      end
    end
    for (int g = 0; g < IFG; g++)
      exp.push_back(mk(g != IFG - 1, 0, (u >= 0) && (g == 0), (u < 0) && (g == 0), 0, 8'h00));

    dest_mac    = dm;
    src_mac     = sm;
    type_length = tl;
    start       = 1'b1;
    k           = 0;
    for (int i = -1; i < exp.size(); i++) begin
      if (i >= 0) begin
        @(negedge clock);
        check($sformatf("pkt%0d cyc%0d", id, i),
              32'({busy, too_long_err, underrun_err, done, control, data}), 32'(exp[i]));
      end
      if (k < n) begin
        pl_data  = pay[k];
        pl_valid = (k != u);
        pl_last  = has_last && (k == n - 1);
      end else begin
        pl_data  = 8'h00;
        pl_valid = 1'b0;
        pl_last  = 1'b0;
      end
      #1;
      if (pl_valid && pl_ready) k++;
    end
    check($sformatf("pkt%0d accepted", id), 32'(k), 32'(sent));
  endtask

  initial begin
    byte_q_t     q;
    int          kind, len, u;
    logic [47:0] dm, sm;
    logic [15:0] tl;
    logic [111:0] hdr;

    reset = 1'b0; start = 1'b0;
    dest_mac = '0; src_mac = '0; type_length = '0;
    pl_data = '0; pl_valid = 1'b0; pl_last = 1'b0;

    repeat (3) @(negedge clock);
    check("reset outs", 32'({control, data, busy, done, underrun_err, too_long_err, pl_ready}), 32'd0);
    reset = 1'b1;

    dm = 48'h0A0B0C0D0E0F; sm = 48'h112233445566; tl = 16'h0800;

    q = {}; for (int i = 1; i <= 46; i++) q.push_back(8'(i));
    run_packet(dm, sm, tl, q, 1, -1, 0);
    q = {}; for (int i = 0; i < 10; i++) q.push_back(8'(8'hA1 + i));
    run_packet(dm, sm, tl, q, 1, -1, 1);
    q = {}; for (int i = 0; i < 20; i++) q.push_back(8'(8'h30 + i));
    run_packet(dm, sm, tl, q, 1, 4, 2);
    q = {}; for (int i = 0; i < 70; i++) q.push_back(8'(i * 3));
    run_packet(dm, sm, tl, q, 0, -1, 3);
    q = {}; for (int i = 0; i < MAX_P; i++) q.push_back(8'(8'hF0 - i));
    run_packet(dm, sm, tl, q, 1, -1, 4);
    q = {}; for (int i = 0; i < 46; i++) q.push_back(8'h00);
    run_packet(dm, sm, tl, q, 1, -1, 5);
    run_packet(dm, sm, tl, q, 1, 0, 6);
    q = {8'h5A};
    run_packet(48'hFFFFFFFFFFFF, sm, 16'h0001, q, 1, -1, 7);

    for (int p = 0; p < 10; p++) begin
      kind = $urandom_range(0, 3);
      dm = 48'({$urandom(), $urandom()});
      sm = 48'({$urandom(), $urandom()});
      tl = 16'($urandom());
      case (kind)
        0:       len = $urandom_range(1, MAX_P);
        1:       len = $urandom_range(1, MAX_P);
        2:       len = $urandom_range(MAX_P + 1, MAX_P + 6);
        default: len = MIN_P - 1 + $urandom_range(0, 2);
      endcase
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
      u = (kind == 1) ? $urandom_range(0, len - 1) : -1;
      run_packet(dm, sm, tl, q, kind != 2, u, 10 + p);
    end

    // Reset while header byte 7 is on the line
    dm = 48'h0A0B0C0D0E0F; sm = 48'h112233445566; tl = 16'h0800;
    hdr = {dm, sm, tl};
    dest_mac = dm; src_mac = sm; type_length = tl;
    pl_valid = 1'b0; start = 1'b1;
    repeat (8) @(negedge clock);
    check("hdr byte7", 32'({control, data}), 32'({1'b1, hdr[111 - 56 -: 8]}));
    #2 reset = 1'b0;
    #1 check("async reset", 32'({control, data, busy, pl_ready}), 32'd0);
    @(negedge clock);
    check("held reset", 32'({control, data, busy}), 32'd0);
    reset = 1'b1;
    q = {}; for (int i = 1; i <= 46; i++) q.push_back(8'(i));
    run_packet(dm, sm, tl, q, 1, -1, 30);

    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("idle%0d", i), 32'({control, data, busy, done}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_packet_tx.md
Name: eth_packet_tx

Overview:
- Transmit-side framer for the Ethernet packet path; it produces the control/data byte stream that the receive-side packet detector consumes.
- On a start request it captures the header fields and emits 14 header bytes with control high: dest MAC, src MAC, type/length.
- It then streams payload bytes from an upstream valid/ready source and pads short payloads to the minimum size.
- It terminates the packet with control low and data 0x00, then holds an inter-frame gap.

Parameters:
- MIN_PAYLOAD, 46, minimum payload bytes; short payloads are zero-padded up to this.
- MAX_PAYLOAD, 1500, maximum payload bytes; the byte that reaches this count ends the payload.
- IFG_CYCLES, 12, number of idle cycles (control=0, data=0x00) after each packet, including the terminator cycle; must be >=1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request to send one packet; sampled only in IDLE
- dest_mac  in  48  destination MAC, captured on start; byte [47:40] sent first
- src_mac  in  48  source MAC, captured on start; byte [47:40] sent first
- type_length  in  16  type/length field, captured on start; byte [15:8] sent first
- pl_data  in  8  payload byte
- pl_valid  in  1  pl_data is valid
- pl_last  in  1  qualifies the final payload byte
- pl_ready  out  1  block accepts pl_data this cycle; transfer occurs when pl_valid && pl_ready
- control  out  1  high while header, payload, pad (and FCS) bytes are on data
- data  out  8  output byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the first IFG cycle of a packet that completed normally
- underrun_err  out  1  one-cycle pulse when a packet is aborted for underrun
- too_long_err  out  1  one-cycle pulse when MAX_PAYLOAD is reached without pl_last

Behaviour:
- Reset (reset=0, async) drives control=0, data=0x00, pl_ready=0, busy=0, done=0, both err=0, state=IDLE, all counters 0. This applies mid-packet: the stream drops immediately and the packet is not resumed.
- control, data, done and the error pulses are registered. pl_ready is combinational from state and counters.
- States: IDLE, HEADER, PAYLOAD, PAD, FCS (only when feature enabled), IFG.
- IDLE:
  - Outputs control=0, data=0x00.
  - start=1 at edge E0 captures the header fields and moves to HEADER.
  - Header byte 0 is on data in the cycle after E0.
- HEADER:
  - Emits 14 bytes on consecutive cycles with control=1, in order dest[47:0], src[47:0], type_length, each MSB byte first.
  - pl_ready=1 in the cycle in which header byte 13 is on data, so the first payload byte follows with no bubble.
- PAYLOAD:
  - pl_ready=1 while in this state.
  - A byte accepted at an edge appears on data the next cycle with control=1. The payload counter increments per accepted byte.
- Underrun: pl_ready=1 && pl_valid=0 aborts the packet.
  - Next cycle: control=0, data=0x00, underrun_err pulses, state=IFG.
  - No padding and no FCS are sent; done is not asserted.
- pl_last accepted:
  - If count < MIN_PAYLOAD, go to PAD.
  - Otherwise go to FCS or IFG.
  - pl_ready drops the cycle after the last accept.
- Count reaches MAX_PAYLOAD on an accepted byte without pl_last: that byte is sent, too_long_err pulses, and the packet ends normally (done asserted). Upstream must drop its remaining bytes.
- PAD: emits 0x00 bytes with control=1 until payload+pad = MIN_PAYLOAD.
- IFG: control=0, data=0x00 for exactly IFG_CYCLES cycles. The first of these cycles is the terminator. Then return to IDLE.
- start while busy is ignored. start held high in IDLE begins the next packet immediately.
- Back-to-back packets: the minimum gap between packets is IFG_CYCLES cycles of control=0.

Optional Feature:
- Macro: ETH_TX_FCS_EN.
- When defined:
  - After payload/pad, state FCS emits 4 bytes with control=1: CRC-32 (IEEE 802.3 polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement).
  - Coverage is all header, payload and pad bytes; the CRC is sent least-significant byte first.
  - Packets aborted for underrun send no FCS.
- When undefined: no FCS state or CRC logic; pad/payload goes directly to IFG.

Test Plan:
- 46-byte payload (0x01..0x2E), IFG_CYCLES=12, dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800 -> control high for exactly 60 cycles (64 with FCS), bytes 0A 0B .. 66 08 00 01..2E, then 12 cycles control=0 data=00, done pulses on the first IFG cycle.
- 10-byte payload with pl_last on byte 10 -> 10 payload bytes, 36 bytes of 0x00 pad, 60 control-high cycles total (no FCS).
- pl_valid low on payload byte 5 -> control falls the cycle after byte 4 is shown, underrun_err=1 for one cycle, done=0, 12 idle cycles.
- MAX_PAYLOAD=16 with 20 bytes offered and no pl_last -> exactly 16 payload bytes sent, too_long_err pulses, done pulses.
- reset asserted during header byte 7 -> control=0, data=00 asynchronously; after release with start=1 a full new packet is sent.
- ETH_TX_FCS_EN, 46 bytes of 0x00 payload with the header above -> the 4 FCS bytes equal a reference CRC-32 model's output; start held high produces a second packet exactly 12 cycles after the first FCS byte 3.
